instr_fetch_unit: RTL and testbench

Upstream stage of the instruction ROM. Holds the program counter, drives the ROM address, and registers the returned instruction into an instruction register (IR) with a valid flag for the decoder.
Handles stall, branch redirect with one-cycle flush, and halt detection. The ROM is purely combinational: data for `rom_addr` is valid in the same cycle.

---
 rtl/instr_fetch_unit.sv | 134 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: program counter, ROM addressing, and the instruction register for the decoder.
// Optional fetch counter output fetch_cnt is enabled by defining FETCH_PERF_CNT_EN.
module instr_fetch_unit #(
   parameter int                   ADDR_W     = 8,
   parameter int                   INSTR_W    = 16,
   parameter logic [ADDR_W-1:0]    RESET_PC   = 8'h00,
   parameter logic [INSTR_W-1:0]   NOP_INSTR  = 16'h0000,
   parameter logic [INSTR_W-1:0]   HALT_INSTR = 16'hFFFF
) (
   input  logic                clk,
   input  logic                rst_n,
   output logic [ADDR_W-1:0]   rom_addr,
   input  logic [INSTR_W-1:0]  rom_instr,
   input  logic                stall,
   input  logic                branch_en,
   input  logic [ADDR_W-1:0]   branch_target,
   output logic [INSTR_W-1:0]  ir_out,
   output logic [ADDR_W-1:0]   ir_pc,
   output logic                ir_valid,
   output logic                halted
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [15:0]         fetch_cnt
`endif
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [ADDR_W-1:0]    r_pc;
   logic [ADDR_W-1:0]    w_pc_nxt;
   logic [INSTR_W-1:0]   r_ir;
   logic [INSTR_W-1:0]   w_ir_nxt;
   logic [ADDR_W-1:0]    r_ir_pc;
   logic [ADDR_W-1:0]    w_ir_pc_nxt;
   logic                 r_ir_valid;
   logic                 w_ir_valid_nxt;
   logic                 r_halted;
   logic                 w_halted_nxt;
   logic                 w_load;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Branch outranks stall; a fetched HALT_INSTR is still delivered as a valid instruction.
   always_comb begin
      w_state_nxt    = r_state;
      w_pc_nxt       = r_pc;
      w_ir_nxt       = r_ir;
      w_ir_pc_nxt    = r_ir_pc;
      w_ir_valid_nxt = r_ir_valid;
      w_halted_nxt   = r_halted;
      w_load         = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_state_nxt = S_RUN;
         end
         S_RUN: begin
            if (branch_en) begin
               w_pc_nxt       = branch_target;
               w_ir_nxt       = NOP_INSTR;
               w_ir_valid_nxt = 1'b0;
            end else if (!stall) begin
               w_load         = 1'b1;
               w_ir_nxt       = rom_instr;
               w_ir_pc_nxt    = r_pc;
               w_ir_valid_nxt = 1'b1;
               if (rom_instr == HALT_INSTR) begin
                  w_halted_nxt = 1'b1;
                  w_state_nxt  = S_HALT;
               end else begin
                  w_pc_nxt = r_pc + ADDR_W'(1);
               end
            end
         end
         S_HALT: begin
            w_ir_valid_nxt = 1'b0;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc       <= RESET_PC;
         r_ir       <= NOP_INSTR;
         r_ir_pc    <= '0;
         r_ir_valid <= 1'b0;
         r_halted   <= 1'b0;
      end else begin
         r_pc       <= w_pc_nxt;
         r_ir       <= w_ir_nxt;
         r_ir_pc    <= w_ir_pc_nxt;
         r_ir_valid <= w_ir_valid_nxt;
         r_halted   <= w_halted_nxt;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [15:0] r_fetch_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fetch_cnt <= '0;
      end else if (w_load && (r_fetch_cnt != 16'hFFFF)) begin
         r_fetch_cnt <= r_fetch_cnt + 16'd1;
      end
   end

   assign fetch_cnt = r_fetch_cnt;
`else
   logic w_load_unused;
   assign w_load_unused = w_load;
`endif

   assign rom_addr = r_pc;
   assign ir_out   = r_ir;
   assign ir_pc    = r_ir_pc;
   assign ir_valid = r_ir_valid;
   assign halted   = r_halted;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a driver steps a behavioural model and queues expected outputs,
// a monitor pops and compares them after every rising edge.
module tb_instr_fetch_unit;

   localparam logic [15:0] NOP  = 16'h0000;
   localparam logic [15:0] HALT = 16'hFFFF;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [7:0]  rom_addr;
   logic [15:0] rom_instr;
   logic        stall = 1'b0;
   logic        branch_en = 1'b0;
   logic [7:0]  branch_target = 8'h00;
   logic [15:0] ir_out;
   logic [7:0]  ir_pc;
   logic        ir_valid;
   logic        halted;
`ifdef FETCH_PERF_CNT_EN
   logic [15:0] fetch_cnt;
`endif

   logic [15:0] rom [256];
   assign rom_instr = rom[rom_addr];

   always #5 clk = ~clk;

   instr_fetch_unit dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .rom_addr      (rom_addr),
      .rom_instr     (rom_instr),
      .stall         (stall),
      .branch_en     (branch_en),
      .branch_target (branch_target),
      .ir_out        (ir_out),
      .ir_pc         (ir_pc),
      .ir_valid      (ir_valid),
      .halted        (halted)
`ifdef FETCH_PERF_CNT_EN
      ,
      .fetch_cnt     (fetch_cnt)
`endif
   );

   typedef struct {
      logic [7:0]  addr;
      logic [15:0] ir;
      logic [7:0]  irpc;
      logic        v;
      logic        h;
      logic [15:0] cnt;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;

   // Reference model: fetch pointer, last delivered instruction, and flags.
   logic [7:0]  m_pc, m_irpc;
   logic [15:0] m_ir, m_cnt;
   logic        m_v, m_h, m_started;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc = 8'h00; m_ir = NOP; m_irpc = 8'h00;
      m_v = 1'b0; m_h = 1'b0; m_started = 1'b0; m_cnt = 16'h0;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_rom_addr"}, 32'(rom_addr), 32'h00);
      chk({tag, "_ir_out"},   32'(ir_out),   32'(NOP));
      chk({tag, "_ir_pc"},    32'(ir_pc),    32'h00);
      chk({tag, "_ir_valid"}, 32'(ir_valid), 32'h0);
      chk({tag, "_halted"},   32'(halted),   32'h0);
`ifdef FETCH_PERF_CNT_EN
      chk({tag, "_fetch_cnt"}, 32'(fetch_cnt), 32'h0);
`endif
   endtask

   // Called at a falling edge: drive inputs, advance model by one rising edge, queue the expectation.
   task automatic step(input bit st, input bit br, input logic [7:0] tgt);
      exp_t e;
      stall = st; branch_en = br; branch_target = tgt;
      if (!m_started) begin
         m_started = 1'b1;
      end else if (m_h) begin
         m_v = 1'b0;
      end else if (br) begin
         m_pc = tgt; m_ir = NOP; m_v = 1'b0;
      end else if (!st) begin
         m_ir = rom[m_pc]; m_irpc = m_pc; m_v = 1'b1;
         if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
         if (m_ir == HALT) m_h = 1'b1;
         else m_pc = 8'((int'(m_pc) + 1) % 256);
      end
      e.addr = m_pc; e.ir = m_ir; e.irpc = m_irpc; e.v = m_v; e.h = m_h; e.cnt = m_cnt;
      sb.push_back(e);
      @(negedge clk);
   endtask

   // Reset asserted between edges and checked before any clock edge can act.
   task automatic do_reset(input string tag);
      #2 rst_n = 1'b0;
      #1 check_reset_vals(tag);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("rom_addr", 32'(rom_addr), 32'(e.addr));
            chk("ir_out",   32'(ir_out),   32'(e.ir));
            chk("ir_pc",    32'(ir_pc),    32'(e.irpc));
            chk("ir_valid", 32'(ir_valid), 32'(e.v));
            chk("halted",   32'(halted),   32'(e.h));
`ifdef FETCH_PERF_CNT_EN
            chk("fetch_cnt", 32'(fetch_cnt), 32'(e.cnt));
`endif
         end
      end
   end

   initial begin : driver
      int waited;
      for (int a = 0; a < 256; a++) rom[a] = 16'h1000 + 16'(a);
      model_reset();
      #1 rst_n = 1'b0;
      #2 check_reset_vals("por");
      @(negedge clk);
      rst_n = 1'b1;

      // Free run of eight instructions, then one branch bubble.
      step(1'b0, 1'b0, 8'h00);
      run(8);
      step(1'b0, 1'b1, 8'h00);
      run(1);

      // Stall three cycles with PC at 3.
      do_reset("rst_stall");
      step(1'b0, 1'b0, 8'h00);
      run(3);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00);
      run(2);

      // Branch together with stall at PC 2, then back-to-back branches.
      do_reset("rst_br");
      step(1'b0, 1'b0, 8'h00);
      run(2);
      step(1'b1, 1'b1, 8'h05);
      run(2);
      step(1'b0, 1'b1, 8'h40);
      step(1'b0, 1'b1, 8'h20);
      run(2);

      // Halt at address 4; branch and stall afterwards must be ignored.
      rom[4] = HALT;
      do_reset("rst_halt");
      step(1'b0, 1'b0, 8'h00);
      run(5);
      step(1'b0, 1'b1, 8'h10);
      step(1'b1, 1'b0, 8'h00);
      run(2);
      do_reset("rst_in_halt");
      rom[4] = 16'h1004;

      // PC wrap from 0xFF to 0x00.
      step(1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b1, 8'hFF);
      run(3);
      do_reset("rst_wrap");

      // Randomized ROM contents and control traffic.
      for (int r = 0; r < 6; r++) begin
         for (int a = 0; a < 256; a++)
            rom[a] = ($urandom_range(0, 31) == 0) ? HALT : 16'($urandom);
         do_reset("rst_rand");
         step(1'b0, 1'b0, 8'h00);
         for (int i = 0; i < 80; i++)
            step($urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0, 8'($urandom));
      end

      waited = 0;
      while (sb.size() != 0 && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      chk("sb_drain", 32'(sb.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
